write_mem_block: RTL and testbench
==================================

WRITE_MEM_BLOCK -- requirements
Module: write_mem

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 12, address width per port.
REQ-002 The block SHALL expose parameter DATA_W, default 32, word width, holding IEEE-754 single-precision patterns by convention.
REQ-003 The block SHALL expose parameter DEPTH, default 4096 (2**ADDR_W), number of words.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports:
- clk  in  1  rising-edge clock shared by both ports
- rst_n  in  1  asynchronous active-low reset
- addra  in  ADDR_W  port A address
- dina  in  DATA_W  port A write data
- ena  in  1  port A enable
- wea  in  1  port A write enable, qualified by ena
- douta  out  DATA_W  port A read data, registered
- addrb  in  ADDR_W  port B address
- dinb  in  DATA_W  port B write data
- enb  in  1  port B enable
- web  in  1  port B write enable, qualified by enb
- doutb  out  DATA_W  port B read data, registered
- collision  out  1  registered flag: both ports enabled on the same address in the previous cycle with at least one writing

Function
REQ-005 The memory SHALL be a true dual-port array of DEPTH x DATA_W words; both ports are fully symmetric and independent.
REQ-006 Port A and port B operations SHALL be sampled on each rising edge of clk while rst_n is high.
REQ-007 Port write: when enX=1 and weX=1, mem[addrX] SHALL take dinX at the edge.
REQ-008 Port read: when enX=1 and weX=0, doutX SHALL present mem[addrX] one cycle after the edge (latency 1).
REQ-009 Same-port behaviour SHALL be write-first: when enX=1 and weX=1, doutX SHALL take dinX at the same edge.
REQ-010 When enX=0, weX SHALL be ignored, memory SHALL be unchanged by that port, and doutX SHALL hold its value.
REQ-011 Cross-port read during write to the same address SHALL be read-first: the reading port returns the old content, and the new word is visible from the next cycle.
REQ-012 When both ports write the same address in one cycle, port A data SHALL be stored, and port B's doutb SHALL show dinb (write-first, REQ-009).
REQ-013 collision SHALL be 1 for exactly one cycle after any edge where ena=enb=1, addra==addrb, and (wea|web)=1; otherwise it SHALL be 0.
REQ-014 Addresses SHALL be used modulo DEPTH; with the default parameters every address is valid.

Reset
REQ-015 Asserting rst_n low SHALL immediately clear douta, doutb and collision to 0, independent of clk.
REQ-016 Reset SHALL NOT modify memory contents, and no write SHALL occur while rst_n is low.
REQ-017 After rst_n deasserts, the first rising edge SHALL be a normal operating edge.
REQ-018 Memory contents after power-up SHALL be undefined; a bench must write a location before reading it.

Configuration
REQ-019 Macro WRITE_MEM_OUTREG_EN, when defined, SHALL add one extra output register stage on douta, doutb and collision:
- read and write-first latency becomes 2 cycles;
- the extra stage is also cleared asynchronously by rst_n;
- the extra stage holds its value when the port's enable was 0 in the previous cycle.
REQ-020 Without WRITE_MEM_OUTREG_EN, the latency SHALL be exactly 1 cycle as specified above.

Verification
REQ-021 Port A writes 0x41400000 @0, 0xBEE9D495 @1, 0x3E6C8B44 @2 and 0x42C80000 @3 on consecutive edges; then reads with A@0 and B@1 -> next cycle douta=0x41400000 and doutb=0xBEE9D495.
REQ-022 Following REQ-021, read A@2 and B@3 -> douta=0x3E6C8B44 and doutb=0x42C80000, with collision=0.
REQ-023 Write A@5=0x11111111 while reading B@5 (old value 0xAAAAAAAA) -> doutb=0xAAAAAAAA, douta=0x11111111, collision=1 for one cycle; the next B read returns 0x11111111.
REQ-024 A and B both write @7 (A=0x1, B=0x2) -> a later read of @7 returns 0x00000001 and collision pulses once.
REQ-025 With douta=0x41400000, drive rst_n low mid-cycle -> douta, doutb and collision go to 0 at once; after release, a read of @0 returns 0x41400000.
REQ-026 With ena=0 and wea=1, apply dina=0xDEADBEEF @0 -> mem[0] is unchanged and douta holds its value.

Source files
------------

// File: rtl/write_mem_block.sv
// True dual-port DEPTH x DATA_W memory: write-first on the same port, read-first across ports, port A wins on a double write.
// Optional macro WRITE_MEM_OUTREG_EN adds a second output register stage on douta, doutb and collision.
module write_mem_block #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              ena,
  input  logic              wea,
  output logic [DATA_W-1:0] douta,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  input  logic              enb,
  input  logic              web,
  output logic [DATA_W-1:0] doutb,
  output logic              collision
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idxa;
  logic [IDX_W-1:0]  w_idxb;
  logic              w_coll;
  logic [DATA_W-1:0] r_douta;
  logic [DATA_W-1:0] r_doutb;
  logic              r_coll;

  assign w_idxa = IDX_W'(32'(addra) % 32'(DEPTH));
  assign w_idxb = IDX_W'(32'(addrb) % 32'(DEPTH));
  assign w_coll = ena & enb & (w_idxa == w_idxb) & (wea | web);

  // Storage has no reset; port B is written first so port A wins a same-address double write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (enb && web) r_mem[w_idxb] <= dinb;
      if (ena && wea) r_mem[w_idxa] <= dina;
    end
  end

  // First output stage: write-first per port, old contents seen by the other port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_douta <= '0;
      r_doutb <= '0;
      r_coll  <= 1'b0;
    end else begin
      if (ena) r_douta <= wea ? dina : r_mem[w_idxa];
      if (enb) r_doutb <= web ? dinb : r_mem[w_idxb];
      r_coll <= w_coll;
    end
  end

`ifdef WRITE_MEM_OUTREG_EN
  logic              r_ena_d;
  logic              r_enb_d;
  logic [DATA_W-1:0] r_douta2;
  logic [DATA_W-1:0] r_doutb2;
  logic              r_coll2;

  // Second output stage: only advances when the first stage was loaded on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ena_d  <= 1'b0;
      r_enb_d  <= 1'b0;
      r_douta2 <= '0;
      r_doutb2 <= '0;
      r_coll2  <= 1'b0;
    end else begin
      r_ena_d <= ena;
      r_enb_d <= enb;
      if (r_ena_d) r_douta2 <= r_douta;
      if (r_enb_d) r_doutb2 <= r_doutb;
      r_coll2 <= r_coll;
    end
  end

  assign douta     = r_douta2;
  assign doutb     = r_doutb2;
  assign collision = r_coll2;
`else
  assign douta     = r_douta;
  assign doutb     = r_doutb;
  assign collision = r_coll;
`endif

endmodule

// File: tb/tb_write_mem_block.sv
// Directed, table-driven bench for write_mem_block in its default (single output stage) build.
module tb_write_mem_block;

  logic        clk;
  logic        rst_n;
  logic [11:0] addra;
  logic [31:0] dina;
  logic        ena;
  logic        wea;
  logic [31:0] douta;
  logic [11:0] addrb;
  logic [31:0] dinb;
  logic        enb;
  logic        web;
  logic [31:0] doutb;
  logic        collision;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        ena;
    logic        wea;
    logic [11:0] addra;
    logic [31:0] dina;
    logic        enb;
    logic        web;
    logic [11:0] addrb;
    logic [31:0] dinb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_c;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  write_mem_block dut (
    .clk(clk), .rst_n(rst_n),
    .addra(addra), .dina(dina), .ena(ena), .wea(wea), .douta(douta),
    .addrb(addrb), .dinb(dinb), .enb(enb), .web(web), .doutb(doutb),
    .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ea, input logic wa, input logic [11:0] aa, input logic [31:0] da,
                              input logic eb, input logic wb, input logic [11:0] ab, input logic [31:0] db,
                              input logic [31:0] xa, input logic [31:0] xb, input logic xc);
    vec_t v;
    v.ena = ea; v.wea = wa; v.addra = aa; v.dina = da;
    v.enb = eb; v.web = wb; v.addrb = ab; v.dinb = db;
    v.exp_a = xa; v.exp_b = xb; v.exp_c = xc;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [11:0] aa, input logic [31:0] da,
                       input logic eb, input logic wb, input logic [11:0] ab, input logic [31:0] db);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Inputs/expectations after the edge that samples them.
    vecs[0]  = mk(1'b1, 1'b1, 12'd0, 32'h41400000, 1'b0, 1'b0, 12'd0, 32'h0, 32'h41400000, 32'h00000000, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 12'd1, 32'hBEE9D495, 1'b0, 1'b0, 12'd0, 32'h0, 32'hBEE9D495, 32'h00000000, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 12'd2, 32'h3E6C8B44, 1'b0, 1'b0, 12'd0, 32'h0, 32'h3E6C8B44, 32'h00000000, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 12'd3, 32'h42C80000, 1'b0, 1'b0, 12'd0, 32'h0, 32'h42C80000, 32'h00000000, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 12'd1, 32'h0, 32'h41400000, 32'hBEE9D495, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 12'd2, 32'h0, 1'b1, 1'b0, 12'd3, 32'h0, 32'h3E6C8B44, 32'h42C80000, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 12'd5, 32'hAAAAAAAA, 32'h3E6C8B44, 32'hAAAAAAAA, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 12'd5, 32'h11111111, 1'b1, 1'b0, 12'd5, 32'h0, 32'h11111111, 32'hAAAAAAAA, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 12'd5, 32'h0, 32'h11111111, 32'h11111111, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 12'd7, 32'h00000001, 1'b1, 1'b1, 12'd7, 32'h00000002, 32'h00000001, 32'h00000002, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 12'd7, 32'h0, 1'b1, 1'b0, 12'd7, 32'h0, 32'h00000001, 32'h00000001, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 12'd0, 32'hDEADBEEF, 1'b0, 1'b0, 12'd0, 32'h0, 32'h00000001, 32'h00000001, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0, 32'h41400000, 32'h00000001, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 12'd3, 32'h0, 1'b1, 1'b0, 12'd3, 32'h0, 32'h42C80000, 32'h42C80000, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 12'd3, 32'h0, 1'b1, 1'b1, 12'd3, 32'h00000055, 32'h42C80000, 32'h00000055, 1'b1);
    vecs[15] = mk(1'b1, 1'b1, 12'd4, 32'h00000066, 1'b1, 1'b0, 12'd3, 32'h0, 32'h00000066, 32'h00000055, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 12'd3, 32'h0, 1'b0, 1'b1, 12'd3, 32'hCAFEF00D, 32'h00000055, 32'h00000055, 1'b0);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0);
    repeat (2) @(negedge clk);
    check32("reset_douta", douta, 32'h0);
    check32("reset_doutb", doutb, 32'h0);
    check1("reset_collision", collision, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ena, vecs[i].wea, vecs[i].addra, vecs[i].dina,
            vecs[i].enb, vecs[i].web, vecs[i].addrb, vecs[i].dinb);
      @(posedge clk);
      @(negedge clk);
      check32($sformatf("vec%0d_douta", i), douta, vecs[i].exp_a);
      check32($sformatf("vec%0d_doutb", i), doutb, vecs[i].exp_b);
      check1($sformatf("vec%0d_collision", i), collision, vecs[i].exp_c);
    end

    // Collision lasts only one cycle when followed by an idle edge.
    drive(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0);
    drive(1'b1, 1'b1, 12'd9, 32'h99, 1'b1, 1'b0, 12'd9, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check1("pulse_high", collision, 1'b1);
    drive(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 12'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check1("pulse_low", collision, 1'b0);
    check32("idle_hold_douta", douta, 32'h00000099);

    // Build nonzero outputs and a live collision, then reset mid-cycle.
    drive(1'b1, 1'b0, 12'd0, 32'h0, 1'b1, 1'b1, 12'd0, 32'h41400000);
    @(posedge clk);
    @(negedge clk);
    check32("pre_rst_douta", douta, 32'h41400000);
    check1("pre_rst_collision", collision, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_rst_douta", douta, 32'h0);
    check32("async_rst_doutb", doutb, 32'h0);
    check1("async_rst_collision", collision, 1'b0);

    // A write attempted during reset must not land.
    drive(1'b1, 1'b1, 12'd0, 32'hDEADBEEF, 1'b1, 1'b1, 12'd1, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    check32("in_rst_douta", douta, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 12'd1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check32("post_rst_read0", douta, 32'h41400000);
    check32("post_rst_read1", doutb, 32'hBEE9D495);
    check1("post_rst_collision", collision, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
